// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared state encoding, symbol constants and helpers for the Morse scheduler
package morse_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TONE,
    ST_SYM_GAP,
    ST_CHAR_GAP,
    ST_SPACE
  } state_t;

  localparam int MAX_SYMBOLS            = 5;
  localparam int DOT_UNITS              = 1;
  localparam int SYM_GAP_UNITS          = 1;
  localparam int DEFAULT_DASH_UNITS     = 3;
  localparam int DEFAULT_CHAR_GAP_UNITS = 3;
  localparam int DEFAULT_SPACE_UNITS    = 4;

  function automatic logic [2:0] clamp_len(input logic [2:0] len);
    return (len > 3'(MAX_SYMBOLS)) ? 3'(MAX_SYMBOLS) : len;
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// rtl/morse_unit_timer.sv - interval timer counting whole units of unit_cycles clocks after each load
module morse_unit_timer
  import morse_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [2:0]    load_units,
  input  logic [CW-1:0] unit_cycles,
  output logic          expire
);

  logic [CW-1:0] cyc_q, cyc_d;
  logic [2:0]    unit_q, unit_d;
  logic [2:0]    units_q, units_d;
  logic          last_cycle;

  always_comb begin
    last_cycle = (cyc_q == unit_cycles - CW'(1));
    expire     = last_cycle && (unit_q == units_q - 3'd1);
    cyc_d      = cyc_q + CW'(1);
    unit_d     = unit_q;
    units_d    = units_q;
    if (load) begin
      cyc_d   = '0;
      unit_d  = '0;
      units_d = load_units;
    end else if (last_cycle) begin
      cyc_d  = '0;
      unit_d = unit_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q   <= '0;
      unit_q  <= '0;
      units_q <= '0;
    end else begin
      cyc_q   <= cyc_d;
      unit_q  <= unit_d;
      units_q <= units_d;
    end
  end

endmodule

// File: rtl/morse_tx_scheduler.sv
// rtl/morse_tx_scheduler.sv - accepts encoded characters and plays dot/dash/gap timing on beep_en
module morse_tx_scheduler
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES    = 25_000_000,
  parameter int DASH_UNITS     = DEFAULT_DASH_UNITS,
  parameter int CHAR_GAP_UNITS = DEFAULT_CHAR_GAP_UNITS,
  parameter int SPACE_UNITS    = DEFAULT_SPACE_UNITS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] speed,
  input  logic       char_valid,
  input  logic [2:0] char_len,
  input  logic [4:0] char_pattern,
  output logic       char_ready,
  output logic       beep_en,
  output logic       busy,
  output logic       char_done
);

  localparam int CW = $clog2(4 * UNIT_CYCLES * SPACE_UNITS + 1);

  state_t        state_q, state_d;
  logic [4:0]    pat_q, pat_d;
  logic [2:0]    len_q, len_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] u_q, u_d;
  logic          beep_q, beep_d;
  logic          done_q, done_d;
  logic          load;
  logic [2:0]    load_units;
  logic          expire;
  logic [2:0]    acc_len;

  morse_unit_timer #(.CW(CW)) u_timer (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_units  (load_units),
    .unit_cycles (u_q),
    .expire      (expire)
  );

  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    len_d      = len_q;
    idx_d      = idx_q;
    u_d        = u_q;
    done_d     = 1'b0;
    load       = 1'b0;
    load_units = '0;
    acc_len    = clamp_len(char_len);
    unique case (state_q)
      ST_IDLE: begin
        if (en && char_valid) begin
          pat_d = char_pattern;
          len_d = acc_len;
          idx_d = '0;
          u_d   = CW'(UNIT_CYCLES) * (CW'(speed) + CW'(1));
          load  = 1'b1;
          if (acc_len == 3'd0) begin
            state_d    = ST_SPACE;
            load_units = 3'(SPACE_UNITS);
          end else begin
            state_d    = ST_TONE;
            load_units = char_pattern[0] ? 3'(DASH_UNITS) : 3'(DOT_UNITS);
          end
        end
      end
      ST_TONE: begin
        if (expire) begin
          load = 1'b1;
          if (idx_q + 3'd1 < len_q) begin
            state_d    = ST_SYM_GAP;
            load_units = 3'(SYM_GAP_UNITS);
          end else begin
            state_d    = ST_CHAR_GAP;
            load_units = 3'(CHAR_GAP_UNITS);
          end
        end
      end
      ST_SYM_GAP: begin
        if (expire) begin
          idx_d      = idx_q + 3'd1;
          state_d    = ST_TONE;
          load       = 1'b1;
          load_units = pat_q[idx_q + 3'd1] ? 3'(DASH_UNITS) : 3'(DOT_UNITS);
        end
      end
      ST_CHAR_GAP, ST_SPACE: begin
        if (expire) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Dropping en discards the in-flight character without a completion pulse
    if (!en && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
    end
    beep_d = (state_d == ST_TONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      u_q     <= '0;
      beep_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      u_q     <= u_d;
      beep_q  <= beep_d;
      done_q  <= done_d;
    end
  end

  assign char_ready = (state_q == ST_IDLE) && en;
  assign busy       = (state_q != ST_IDLE);
  assign beep_en    = beep_q;
  assign char_done  = done_q;

endmodule

// File: tb/tb_morse_tx_scheduler.sv
// tb/tb_morse_tx_scheduler.sv - self-checking bench for morse_tx_scheduler against a waveform model
module tb_morse_tx_scheduler;

  localparam int UC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] speed;
  logic       char_valid;
  logic [2:0] char_len;
  logic [4:0] char_pattern;
  logic       char_ready;
  logic       beep_en;
  logic       busy;
  logic       char_done;

  int n_assert = 0;
  int n_fail   = 0;
  bit exp_q[$];

  morse_tx_scheduler #(.UNIT_CYCLES(UC)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .speed        (speed),
    .char_valid   (char_valid),
    .char_len     (char_len),
    .char_pattern (char_pattern),
    .char_ready   (char_ready),
    .beep_en      (beep_en),
    .busy         (busy),
    .char_done    (char_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected beep_en level for every busy cycle, built straight from the symbol timing rules
  task automatic build_model(input int len, input logic [4:0] pat, input int spd);
    int u, n;
    u = UC * (spd + 1);
    n = (len > 5) ? 5 : len;
    exp_q.delete();
    if (n == 0) begin
      repeat (4 * u) exp_q.push_back(1'b0);
    end else begin
      for (int i = 0; i < n; i++) begin
        repeat ((pat[i] ? 3 : 1) * u) exp_q.push_back(1'b1);
        if (i < n - 1) repeat (u) exp_q.push_back(1'b0);
      end
      repeat (3 * u) exp_q.push_back(1'b0);
    end
  endtask

  task automatic play(input string name, input logic [2:0] len, input logic [4:0] pat, input logic [1:0] spd);
    build_model(int'(len), pat, int'(spd));
    chk({name, "_ready"}, char_ready, 1);
    char_valid   = 1'b1;
    char_len     = len;
    char_pattern = pat;
    speed        = spd;
    step();
    char_valid = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("%s_beep_%0d", name, i), beep_en, exp_q[i]);
      chk($sformatf("%s_busy_%0d", name, i), busy, 1);
      chk($sformatf("%s_nodone_%0d", name, i), char_done, 0);
      char_len     = 3'($urandom);
      char_pattern = 5'($urandom);
      speed        = 2'($urandom);
      step();
    end
    chk({name, "_done"}, char_done, 1);
    chk({name, "_done_ready"}, char_ready, 1);
    chk({name, "_done_idle"}, busy, 0);
    chk({name, "_done_beep"}, beep_en, 0);
    step();
    chk({name, "_done_pulse"}, char_done, 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; speed = 2'd0; char_valid = 1'b0; char_len = 3'd0; char_pattern = 5'd0;
    step(); step();
    chk("rst_beep", beep_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", char_done, 0);
    rst = 1'b0;
    step();
    chk("idle_ready", char_ready, 1);

    // en low in IDLE: not ready, nothing accepted
    en = 1'b0; char_valid = 1'b1; char_len = 3'd1;
    #1 chk("en0_ready", char_ready, 0);
    step(); step();
    chk("en0_busy", busy, 0);
    char_valid = 1'b0; en = 1'b1;
    #1;

    play("E", 3'd1, 5'b00000, 2'd0);
    play("A", 3'd2, 5'b00010, 2'd0);
    play("SPACE", 3'd0, 5'b10101, 2'd0);
    play("T", 3'd1, 5'b00001, 2'd1);
    play("clamp", 3'd7, 5'b10110, 2'd0);
    for (int k = 0; k < 8; k++)
      play($sformatf("rnd%0d", k), 3'($urandom), 5'($urandom), 2'($urandom));

    // Abort during 'A': en low in cycle N+6
    char_valid = 1'b1; char_len = 3'd2; char_pattern = 5'b00010; speed = 2'd0;
    step();
    char_valid = 1'b0;
    for (int c = 1; c <= 5; c++) step();
    en = 1'b0;
    step();
    chk("abort_beep", beep_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", char_done, 0);
    chk("abort_ready_low", char_ready, 0);
    en = 1'b1;
    #1 chk("abort_ready_back", char_ready, 1);
    for (int c = 0; c < 20; c++) begin
      step();
      chk($sformatf("abort_nodone_%0d", c), char_done, 0);
    end

    // Back-to-back 'E','E' with char_valid held, then reset mid-tone
    char_valid = 1'b1; char_len = 3'd1; char_pattern = 5'b00000; speed = 2'd0;
    step();
    for (int c = 1; c <= 16; c++) step();
    chk("b2b_done", char_done, 1);
    chk("b2b_ready", char_ready, 1);
    step();
    char_valid = 1'b0;
    chk("b2b_beep18", beep_en, 1);
    chk("b2b_busy18", busy, 1);
    step();
    chk("b2b_beep19", beep_en, 1);
    rst = 1'b1;
    step();
    chk("b2b_rst_beep", beep_en, 0);
    chk("b2b_rst_busy", busy, 0);
    chk("b2b_rst_done", char_done, 0);
    rst = 1'b0;
    step();
    chk("b2b_after_ready", char_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
